// File: rtl/fp_mul_mant_iter.sv
// Iterative radix-2 shift-and-add mantissa multiplier with one-step normalization.
// Optional FP_MUL_ZERO_SKIP_EN: zero operands bypass the iterations and finish in one cycle.
module fp_mul_mant_iter #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_out,
  output logic              guard_bit,
  output logic              round_bit,
  output logic [MANT_W-3:0] discard,
  output logic              norm_inc
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [MANT_W-1:0]   a_q, a_d;
  logic [MANT_W:0]     acc_q, acc_d;
  logic [MANT_W-1:0]   mplr_q, mplr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic                guard_q, guard_d;
  logic                round_q, round_d;
  logic [MANT_W-3:0]   discard_q, discard_d;
  logic                norm_q, norm_d;

  logic [MANT_W:0]     sum;
  logic [2*MANT_W-1:0] prod;
`ifdef FP_MUL_ZERO_SKIP_EN
  logic                zero_op;
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    acc_d     = acc_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    mant_d    = mant_q;
    guard_d   = guard_q;
    round_d   = round_q;
    discard_d = discard_q;
    norm_d    = norm_q;

    sum  = acc_q + (mplr_q[0] ? {1'b0, a_q} : '0);
    // Full product as it stands after this iteration's right shift.
    prod = {sum, mplr_q[MANT_W-1:1]};
`ifdef FP_MUL_ZERO_SKIP_EN
    zero_op = (mant_a == '0) || (mant_b == '0);
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = mant_a;
          mplr_d  = mant_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StBusy;
`ifdef FP_MUL_ZERO_SKIP_EN
          if (zero_op) begin
            state_d   = StDone;
            mant_d    = '0;
            guard_d   = 1'b0;
            round_d   = 1'b0;
            discard_d = '0;
            norm_d    = 1'b0;
          end
`endif
        end
      end
      StBusy: begin
        acc_d  = {1'b0, sum[MANT_W:1]};
        mplr_d = {sum[0], mplr_q[MANT_W-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MANT_W - 1)) begin
          state_d = StDone;
          if (prod[2*MANT_W-1]) begin
            mant_d    = prod[2*MANT_W-1 -: MANT_W];
            guard_d   = prod[MANT_W-1];
            round_d   = prod[MANT_W-2];
            discard_d = prod[MANT_W-3:0];
            norm_d    = 1'b1;
          end else begin
            mant_d    = prod[2*MANT_W-2 -: MANT_W];
            guard_d   = prod[MANT_W-2];
            round_d   = prod[MANT_W-3];
            discard_d = {prod[MANT_W-4:0], 1'b0};
            norm_d    = 1'b0;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      acc_q     <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      mant_q    <= '0;
      guard_q   <= 1'b0;
      round_q   <= 1'b0;
      discard_q <= '0;
      norm_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      mant_q    <= mant_d;
      guard_q   <= guard_d;
      round_q   <= round_d;
      discard_q <= discard_d;
      norm_q    <= norm_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign mant_out  = mant_q;
  assign guard_bit = guard_q;
  assign round_bit = round_q;
  assign discard   = discard_q;
  assign norm_inc  = norm_q;

endmodule

// File: tb/tb_fp_mul_mant_iter.sv
// Self-checking bench for fp_mul_mant_iter: directed vectors, random operands against an
// integer-arithmetic reference, backpressure, mid-operation reset and zero operands.
module tb_fp_mul_mant_iter;

  localparam int W = 24;
`ifdef FP_MUL_ZERO_SKIP_EN
  localparam int ZeroLat = 1;
`else
  localparam int ZeroLat = W + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  mant_a = '0;
  logic [W-1:0]  mant_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  mant_out;
  logic          guard_bit;
  logic          round_bit;
  logic [W-3:0]  discard;
  logic          norm_inc;

  int errors = 0;
  int checks = 0;

  fp_mul_mant_iter #(.MANT_W(W), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_a    (mant_a),
    .mant_b    (mant_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .guard_bit (guard_bit),
    .round_bit (round_bit),
    .discard   (discard),
    .norm_inc  (norm_inc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product, then the normalization rules on plain shifts.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] m, output logic g, output logic r,
                       output logic [W-3:0] d, output logic n);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    if (((p >> (2*W-1)) & 1) == 1) begin
      m = W'(p >> W);
      g = 1'((p >> (W-1)) & 1);
      r = 1'((p >> (W-2)) & 1);
      d = (W-2)'(p);
      n = 1'b1;
    end else begin
      m = W'(p >> (W-1));
      g = 1'((p >> (W-2)) & 1);
      r = 1'((p >> (W-3)) & 1);
      d = (W-2)'(p << 1);
      n = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] m;
    logic g, r, n;
    logic [W-3:0] d;
    model(a, b, m, g, r, d, n);
    check({tag, ".mant"}, 64'(mant_out), 64'(m));
    check({tag, ".guard"}, 64'(guard_bit), 64'(g));
    check({tag, ".round"}, 64'(round_bit), 64'(r));
    check({tag, ".discard"}, 64'(discard), 64'(d));
    check({tag, ".norm"}, 64'(norm_inc), 64'(n));
  endtask

  // Accept a/b, scramble the inputs while busy, check latency and result, hold `hold`
  // cycles under backpressure with in_valid up, then release.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    int n;
    int exp_lat;
    exp_lat = (a == '0 || b == '0) ? ZeroLat : W + 1;
    check({tag, ".in_ready_idle"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    mant_a = a;
    mant_b = b;
    @(negedge clk);
    n = 1;
    while (!out_valid && n < 100) begin
      if (n == 2) check({tag, ".in_ready_busy"}, 64'(in_ready), 64'(0));
      in_valid = 1'($urandom);
      mant_a = W'($urandom);
      mant_b = W'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(exp_lat));
    out_ready = 1'b0;
    in_valid = 1'b1;
    mant_a = W'($urandom);
    mant_b = W'($urandom);
    check_outputs(tag, a, b);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".bp_valid"}, 64'(out_valid), 64'(1));
      check({tag, ".bp_in_ready"}, 64'(in_ready), 64'(0));
      check_outputs({tag, ".bp"}, a, b);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".release_valid"}, 64'(out_valid), 64'(0));
    check({tag, ".release_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    #12;
    check("reset.in_ready", 64'(in_ready), 64'(1));
    check("reset.out_valid", 64'(out_valid), 64'(0));
    check("reset.mant", 64'(mant_out), 64'(0));
    check("reset.grd", 64'({guard_bit, round_bit, norm_inc}), 64'(0));
    check("reset.discard", 64'(discard), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op("v_800000", 24'h800000, 24'h800000, 0);
    run_op("v_C00000", 24'hC00000, 24'hC00000, 5);
    run_op("v_FFFFFF", 24'hFFFFFF, 24'hFFFFFF, 0);
    run_op("v_800001", 24'h800001, 24'h800001, 2);

    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom) | 24'h800000;
      rb = W'($urandom) | 24'h800000;
      run_op("rnd_norm", ra, rb, int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op("rnd_any", ra, rb, 1);
    end

    // Reset at BUSY iteration 10 discards the operation.
    in_valid = 1'b1;
    mant_a = 24'hFFFFFF;
    mant_b = 24'hABCDEF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset.out_valid", 64'(out_valid), 64'(0));
    check("midreset.in_ready", 64'(in_ready), 64'(1));
    check("midreset.mant", 64'(mant_out), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postreset.out_valid", 64'(out_valid), 64'(0));
    run_op("post_reset", 24'hC00000, 24'hC00000, 0);

    run_op("zero_a", 24'h000000, 24'hABCDEF, 1);
    run_op("zero_b", 24'h9ABCDE, 24'h000000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
